mul_te_seq: RTL and testbench



---
 rtl/trit_pkg.sv | 18 +
 rtl/mul_te.sv | 30 +++
 rtl/mul_te_seq.sv | 121 ++++++++++++
 tb/tb_mul_te_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/trit_pkg.sv
// rtl/trit_pkg.sv - shared trit codes and sequencer state type
// Contents:
//   TRIT_POS / TRIT_ZERO / TRIT_NEG / TRIT_ERR : 2-bit balanced-ternary codes
//   mul_te_seq_state_t                         : IDLE / RUN / DONE sequencer states
package trit_pkg;

    localparam logic [1:0] TRIT_POS  = 2'b10;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_NEG  = 2'b01;
    localparam logic [1:0] TRIT_ERR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_te_seq_state_t;

endpackage

// File: rtl/mul_te.sv
// rtl/mul_te.sv - combinational single-trit multiplier
// Ports:
//   a, b : input trits (2-bit codes from trit_pkg)
//   p    : product trit (TRIT_ERR when err is set)
//   err  : either input is the invalid code
module mul_te
    import trit_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] p,
    output logic       err
);

    always_comb begin
        p   = TRIT_ZERO;
        err = 1'b0;
        if (a == TRIT_ERR || b == TRIT_ERR) begin
            p   = TRIT_ERR;
            err = 1'b1;
        end else if (a == TRIT_ZERO || b == TRIT_ZERO) begin
            p = TRIT_ZERO;
        end else if (a == b) begin
            p = TRIT_POS;
        end else begin
            p = TRIT_NEG;
        end
    end

endmodule

// File: rtl/mul_te_seq.sv
// rtl/mul_te_seq.sv - sequential ternary dot-product controller, one trit per clock
// Optional build macro: MUL_TE_SEQ_ABORT_EN (stop at the first invalid trit pair)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, a, b     : operation request and two N-trit operand words
//   ready/busy/done : IDLE / RUN / one-cycle DONE status
//   c               : element-wise product word
//   sum             : signed sum of valid trit products
//   err, err_idx    : sticky error flag and index of first erroring trit
module mul_te_seq
    import trit_pkg::*;
#(
    parameter int N  = 9,
    localparam int SW = $clog2(N + 1) + 1,
    localparam int EW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*N-1:0]       a,
    input  logic [2*N-1:0]       b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*N-1:0]       c,
    output logic signed [SW-1:0] sum,
    output logic                 err,
    output logic [EW-1:0]        err_idx
);

    mul_te_seq_state_t state, state_nxt;

    logic [2*N-1:0]       a_sh, b_sh;
    logic [EW-1:0]        idx;
    logic [1:0]           prod;
    logic                 prod_err;
    logic signed [SW-1:0] inc;
    logic                 last_trit;

    // Operands shift right so the current trit pair is always in bits [1:0].
    mul_te u_mul (
        .a   (a_sh[1:0]),
        .b   (b_sh[1:0]),
        .p   (prod),
        .err (prod_err)
    );

    always_comb begin
        inc = '0;
        if (!prod_err) begin
            if (prod == TRIT_POS)      inc = SW'(1);
            else if (prod == TRIT_NEG) inc = -SW'(1);
        end
    end

    assign last_trit = (idx == EW'(N - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (last_trit) state_nxt = ST_DONE;
`ifdef MUL_TE_SEQ_ABORT_EN
                if (prod_err && !err) state_nxt = ST_DONE;
`endif
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            idx     <= '0;
            c       <= '0;
            sum     <= '0;
            err     <= 1'b0;
            err_idx <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        idx     <= '0;
                        c       <= '0;
                        sum     <= '0;
                        err     <= 1'b0;
                        err_idx <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> 2;
                    b_sh <= b_sh >> 2;
                    idx  <= idx + EW'(1);
                    if (prod_err) begin
                        c[2*idx +: 2] <= TRIT_ERR;
                        if (!err) begin
                            err     <= 1'b1;
                            err_idx <= idx;
                        end
                    end else begin
                        c[2*idx +: 2] <= prod;
                        sum           <= sum + inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_te_seq.sv
// tb/tb_mul_te_seq.sv - directed self-checking bench for mul_te_seq
module tb_mul_te_seq;

    localparam int N  = 9;
    localparam int SW = 5;
    localparam int EW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [2*N-1:0]       a, b;
    logic                 ready, busy, done;
    logic [2*N-1:0]       c;
    logic signed [SW-1:0] sum;
    logic                 err;
    logic [EW-1:0]        err_idx;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2*N-1:0] ALL_POS = 18'h2AAAA;
    localparam logic [2*N-1:0] ALL_NEG = 18'h15555;
    localparam logic [2*N-1:0] ERR3_A  = 18'h2AAEA;

    mul_te_seq #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .c       (c),
        .sum     (sum),
        .err     (err),
        .err_idx (err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Presents one start, then waits
    // for done; returns accept-to-done cycle count and whether ready was ever
    // seen high while the operation was in flight. Optionally pulses start at
    // in-flight cycles 2 and N.
    task automatic run_op(input logic [2*N-1:0] va, input logic [2*N-1:0] vb,
                          input bit inject, output int cyc, output bit ready_hi);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb;
        cyc = 0;
        ready_hi = 1'b0;
        while (!done && cyc < 40) begin
            if (ready) ready_hi = 1'b1;
            start = inject && (cyc == 1 || cyc == N - 1);
            @(negedge clk);
            cyc++;
        end
        if (ready) ready_hi = 1'b1;
        start = 1'b0;
    endtask

    int cyc;
    bit rhi;
    int seen_done;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c", c, 0);
        check("rst_sum", int'(sum), 0);
        check("rst_err", err, 0);
        check("rst_err_idx", err_idx, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // +1 x +1
        run_op(ALL_POS, ALL_POS, 1'b0, cyc, rhi);
        check("pos_latency", cyc, 9);
        check("pos_c", c, ALL_POS);
        check("pos_sum", int'(sum), 9);
        check("pos_err", err, 0);
        check("pos_ready_low", rhi, 0);
        @(negedge clk);
        check("pos_ready_back", ready, 1);
        check("pos_c_hold", c, ALL_POS);

        // +1 x -1
        run_op(ALL_POS, ALL_NEG, 1'b0, cyc, rhi);
        check("neg_c", c, ALL_NEG);
        check("neg_sum", int'(sum), -9);
        @(negedge clk);

        // 0 x -1
        run_op('0, ALL_NEG, 1'b0, cyc, rhi);
        check("zero_c", c, 0);
        check("zero_sum", int'(sum), 0);
        @(negedge clk);

        // invalid trit 3 in a
        run_op(ERR3_A, ALL_POS, 1'b0, cyc, rhi);
        check("err_flag", err, 1);
        check("err_idx", err_idx, 3);
        check("err_c_trit3", c[7:6], 2'b11);
`ifdef MUL_TE_SEQ_ABORT_EN
        check("err_sum", int'(sum), 3);
        check("err_c_upper", c[17:8], 0);
        check("err_latency", cyc, 4);
        check("err_c", c, 18'h000EA);
`else
        check("err_sum", int'(sum), 8);
        check("err_latency", cyc, 9);
        check("err_c", c, ERR3_A);
`endif
        @(negedge clk);

        // start pulses during RUN/DONE are ignored
        run_op(ALL_POS, ALL_NEG, 1'b1, cyc, rhi);
        check("inj_latency", cyc, 9);
        check("inj_c", c, ALL_NEG);
        check("inj_sum", int'(sum), -9);
        check("inj_ready_low", rhi, 0);
        @(negedge clk);
        check("inj_not_queued", busy, 0);
        @(negedge clk);
        check("inj_still_idle", ready, 1);

        // reset mid-run at i=4
        a = ALL_POS; b = ALL_POS; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_ready", ready, 1);
        check("abort_c", c, 0);
        check("abort_sum", int'(sum), 0);
        check("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        run_op(ALL_NEG, ALL_NEG, 1'b0, cyc, rhi);
        check("after_abort_c", c, ALL_POS);
        check("after_abort_sum", int'(sum), 9);
        check("after_abort_latency", cyc, 9);

        // back-to-back: next start in first ready cycle
        @(negedge clk);
        check("b2b_hold_c", c, ALL_POS);
        run_op(ALL_NEG, ALL_POS, 1'b0, cyc, rhi);
        check("b2b_c", c, ALL_NEG);
        check("b2b_sum", int'(sum), -9);
        check("b2b_latency", cyc, 9);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
